// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice face bank.
package dice_pkg;

  typedef enum logic [1:0] {IDLE, ROLL, SETTLE} dice_state_e;

  localparam int unsigned DICE_FACES_DEF = 6;
  localparam int unsigned DICE_N_DEF     = 2;

  // Wrap-to-1 increment; zero is never produced.
  function automatic logic [3:0] face_next(input logic [3:0] face, input logic [3:0] faces);
    return (face >= faces) ? 4'd1 : face + 4'd1;
  endfunction

endpackage

// File: rtl/dice_face_cell.sv
// One die: face register with clamped load, step on carry-in, carry-out on wrap or hold.
module dice_face_cell
  import dice_pkg::*;
#(
  parameter int unsigned FACES = DICE_FACES_DEF,
  parameter int unsigned FW    = 3
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [FW-1:0] load_face_i,
  input  logic          carry_i,
  input  logic          hold_i,
  output logic [FW-1:0] face_o,
  output logic          carry_o
);

  logic [FW-1:0] face_q, face_d;
  logic          wrap;

  always_comb begin
    wrap   = (face_q == FW'(FACES));
    face_d = face_q;
    if (load_i) begin
      if ((load_face_i == '0) || (load_face_i > FW'(FACES))) face_d = FW'(1);
      else                                                   face_d = load_face_i;
    end else if (carry_i && !hold_i) begin
      face_d = FW'(face_next(4'(face_q), 4'(FACES)));
    end
    // A held die forwards its carry-in as though it had wrapped.
    carry_o = carry_i && (hold_i || wrap);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) face_q <= FW'(1);
    else       face_q <= face_d;
  end

  assign face_o = face_q;

endmodule

// File: rtl/dice_face_bank.sv
// Bank of N_DICE odometer-chained dice with roll/settle FSM, registered sum and done pulse.
// Optional per-die lock mask enabled by defining DICE_LOCK_EN.
module dice_face_bank
  import dice_pkg::*;
#(
  parameter  int unsigned N_DICE = DICE_N_DEF,
  parameter  int unsigned FACES  = DICE_FACES_DEF,
  localparam int unsigned FW     = $clog2(FACES + 1),
  localparam int unsigned SW     = $clog2(N_DICE * FACES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               roll_i,
  input  logic               load_i,
  input  logic [FW-1:0]      load_face_i,
  input  logic [N_DICE-1:0]  lock_i,
  output logic [N_DICE*FW-1:0] face_o,
  output logic [SW-1:0]      sum_o,
  output logic               done_o,
  output logic               rolling_o
);

  dice_state_e   state_q, state_d;
  logic [SW-1:0] sum_q, sum_d;
  logic          done_q, done_d;
  logic          step_en;
  logic [N_DICE:0]   carry;
  logic [N_DICE-1:0] hold;
  logic [FW-1:0]     face_w [N_DICE];
  logic              unused_bits;

`ifdef DICE_LOCK_EN
  assign hold        = lock_i;
  assign unused_bits = carry[N_DICE];
`else
  assign hold        = '0;
  assign unused_bits = ^{carry[N_DICE], lock_i};
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: if (roll_i) begin
        state_d = ROLL;
        step_en = 1'b1;
      end
      ROLL: begin
        if (roll_i) step_en = 1'b1;
        else        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (load_i) begin
      state_d = IDLE;
      done_d  = 1'b0;
      step_en = 1'b0;
    end
  end

  assign carry[0] = step_en;

  for (genvar k = 0; k < N_DICE; k++) begin : g_die
    dice_face_cell #(
      .FACES (FACES),
      .FW    (FW)
    ) u_cell (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .load_i      (load_i),
      .load_face_i (load_face_i),
      .carry_i     (carry[k]),
      .hold_i      (hold[k]),
      .face_o      (face_w[k]),
      .carry_o     (carry[k+1])
    );
    assign face_o[k*FW +: FW] = face_w[k];
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned k = 0; k < N_DICE; k++) sum_d = sum_d + SW'(face_w[k]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sum_q   <= SW'(N_DICE);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  assign sum_o     = sum_q;
  assign done_o    = done_q;
  assign rolling_o = (state_q == ROLL);

endmodule

// File: tb/tb_dice_face_bank.sv
// Scoreboard bench for dice_face_bank (N_DICE=2, FACES=6); lock vectors follow DICE_LOCK_EN.
module tb_dice_face_bank;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       roll_i = 1'b0;
  logic       load_i = 1'b0;
  logic [2:0] load_face_i = '0;
  logic [1:0] lock_i = '0;
  logic [5:0] face_o;
  logic [3:0] sum_o;
  logic       done_o;
  logic       rolling_o;

  typedef struct {
    int         id;
    logic [2:0] f0;
    logic [2:0] f1;
    logic [3:0] sum;
    logic       done;
    logic       rol;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;
  bit   stim_done = 1'b0;

  dice_face_bank #(
    .N_DICE (2),
    .FACES  (6)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .roll_i      (roll_i),
    .load_i      (load_i),
    .load_face_i (load_face_i),
    .lock_i      (lock_i),
    .face_o      (face_o),
    .sum_o       (sum_o),
    .done_o      (done_o),
    .rolling_o   (rolling_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic rst, input logic roll, input logic ld, input logic [2:0] lf,
                     input logic [1:0] lk, input logic [2:0] e0, input logic [2:0] e1,
                     input logic [3:0] es, input logic ed, input logic er);
    exp_t e;
    @(negedge clk_i);
    rst_i = rst; roll_i = roll; load_i = ld; load_face_i = lf; lock_i = lk;
    vec_id++;
    e.id = vec_id; e.f0 = e0; e.f1 = e1; e.sum = es; e.done = ed; e.rol = er;
    exp_q.push_back(e);
  endtask

  task automatic chk(input int id, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL vec%0d %s actual=%0d required=%0d", id, name, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.id, "die0",    int'(face_o[2:0]), int'(e.f0));
        chk(e.id, "die1",    int'(face_o[5:3]), int'(e.f1));
        chk(e.id, "sum",     int'(sum_o),       int'(e.sum));
        chk(e.id, "done",    int'(done_o),      int'(e.done));
        chk(e.id, "rolling", int'(rolling_o),   int'(e.rol));
      end
    end
  end

  initial begin : stimulus
    //   rst roll ld lf    lock   d0 d1 sum done rol
    cyc(1, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    cyc(1, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    // odometer: eight stepping cycles from reset
    cyc(0, 1, 0, 3'd0, 2'b00, 2, 1, 2,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 3, 1, 3,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 4, 1, 4,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 5, 1, 5,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 6, 1, 6,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 1, 2, 7,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 2, 2, 3,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 3, 2, 4,  0, 1);
    cyc(0, 0, 0, 3'd0, 2'b00, 3, 2, 5,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 3, 2, 5,  1, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 3, 2, 5,  0, 0);
    // loads, including clamped out-of-range values
    cyc(0, 0, 1, 3'd4, 2'b00, 4, 4, 5,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 4, 4, 8,  0, 0);
    cyc(0, 0, 1, 3'd0, 2'b00, 1, 1, 8,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    cyc(0, 0, 1, 3'd3, 2'b00, 3, 3, 2,  0, 0);
    cyc(0, 0, 1, 3'd7, 2'b00, 1, 1, 6,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    // load aborts a roll without a done pulse
    cyc(0, 1, 0, 3'd0, 2'b00, 2, 1, 2,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 3, 1, 3,  0, 1);
    cyc(0, 1, 1, 3'd5, 2'b00, 5, 5, 4,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 5, 5, 10, 0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 5, 5, 10, 0, 0);
    // reset aborts a roll without a done pulse
    cyc(0, 1, 0, 3'd0, 2'b00, 6, 5, 10, 0, 1);
    cyc(0, 1, 0, 3'd0, 2'b00, 1, 6, 11, 0, 1);
    cyc(1, 1, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    // roll re-asserted during SETTLE is taken only from IDLE
    cyc(0, 1, 0, 3'd0, 2'b00, 2, 1, 2,  0, 1);
    cyc(0, 0, 0, 3'd0, 2'b00, 2, 1, 3,  0, 0);
    cyc(0, 1, 0, 3'd0, 2'b00, 2, 1, 3,  1, 0);
    cyc(0, 1, 0, 3'd0, 2'b00, 3, 1, 3,  0, 1);
    cyc(0, 0, 0, 3'd0, 2'b00, 3, 1, 4,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 3, 1, 4,  1, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 3, 1, 4,  0, 0);
    // both dice wrap 6->1 on the same edge
    cyc(0, 0, 1, 3'd6, 2'b00, 6, 6, 4,  0, 0);
    cyc(0, 1, 0, 3'd0, 2'b00, 1, 1, 12, 0, 1);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  1, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
    // lock mask 01: honoured only with DICE_LOCK_EN
`ifdef DICE_LOCK_EN
    cyc(0, 1, 0, 3'd0, 2'b01, 1, 2, 2,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 1, 3, 3,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 1, 4, 4,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 1, 5, 5,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 1, 6, 6,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 1, 1, 7,  0, 1);
    cyc(0, 0, 0, 3'd0, 2'b01, 1, 1, 2,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  1, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 1, 2,  0, 0);
`else
    cyc(0, 1, 0, 3'd0, 2'b01, 2, 1, 2,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 3, 1, 3,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 4, 1, 4,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 5, 1, 5,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 6, 1, 6,  0, 1);
    cyc(0, 1, 0, 3'd0, 2'b01, 1, 2, 7,  0, 1);
    cyc(0, 0, 0, 3'd0, 2'b01, 1, 2, 3,  0, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 2, 3,  1, 0);
    cyc(0, 0, 0, 3'd0, 2'b00, 1, 2, 3,  0, 0);
`endif
    stim_done = 1'b1;
  end

  initial begin : finisher
    int waited;
    wait (stim_done);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk_i);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL timeout actual=stuck required=finish");
    $fatal(1, "timeout");
  end

endmodule
